// File: rtl/pool_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pool_engine: streaming non-overlapping PxP max/average pooling of an MxM |
// | raster. Define POOL_ENGINE_AVG_EN to build the average datapath.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pool_engine #(
    parameter int DW = 32,
    parameter int M  = 4,
    parameter int P  = 2
) (
    input  logic          clk,
    input  logic          master_rst,
    input  logic          ce,
    input  logic          mode,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          valid_op,
    output logic          end_op
);
    localparam int LP = $clog2(P);
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam int NB = M / P;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
`ifdef POOL_ENGINE_AVG_EN
    localparam int BW = DW + 2 * LP;
`else
    localparam int BW = DW;
`endif

    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic [BW-1:0] buf_q [NB];
    logic [BW-1:0] buf_d [NB];
    logic [DW-1:0] dout_q, dout_d;
    logic          valid_q, valid_d, end_q, end_d;

    logic [IW-1:0] w_idx;
    logic          w_first, w_last, w_map_start;
    logic [BW-1:0] w_ext, w_entry, w_upd, w_new;
    logic [DW-1:0] w_result;

    assign w_idx       = IW'(col_q >> LP);
    assign w_entry     = buf_q[w_idx];
    assign w_map_start = (row_q == '0) && (col_q == '0);
    // P is a power of two, so the in-window offset is just the low LP bits.
    assign w_first     = (row_q[LP-1:0] == '0) && (col_q[LP-1:0] == '0);
    assign w_last      = (row_q[LP-1:0] == '1) && (col_q[LP-1:0] == '1);
    assign w_new       = w_first ? w_ext : w_upd;

`ifdef POOL_ENGINE_AVG_EN
    logic mode_q, mode_d, w_avg;

    assign w_ext = {{(2 * LP){data_in[DW-1]}}, data_in};
    // The first pixel of a map uses the incoming mode before it is latched.
    assign w_avg = w_map_start ? mode : mode_q;

    always_comb begin
        if (w_avg) begin
            w_upd = w_entry + w_ext;
        end else begin
            w_upd = ($signed(w_ext) > $signed(w_entry)) ? w_ext : w_entry;
        end
    end

    assign w_result = w_avg ? DW'($signed(w_new) >>> (2 * LP)) : w_new[DW-1:0];

    always_comb begin
        mode_d = mode_q;
        if (ce && w_map_start) begin
            mode_d = mode;
        end
    end

    always_ff @(posedge clk) begin
        if (master_rst) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end
`else
    logic w_unused_mode;

    assign w_unused_mode = mode;
    assign w_ext         = data_in;
    assign w_upd         = ($signed(w_ext) > $signed(w_entry)) ? w_ext : w_entry;
    assign w_result      = w_new;
`endif

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        buf_d   = buf_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        end_d   = 1'b0;
        if (ce) begin
            buf_d[w_idx] = w_new;
            if (col_q == CW'(M - 1)) begin
                col_d = '0;
                row_d = (row_q == CW'(M - 1)) ? '0 : row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (w_last) begin
                dout_d  = w_result;
                valid_d = 1'b1;
                end_d   = (row_q == CW'(M - 1)) && (col_q == CW'(M - 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (master_rst) begin
            col_q   <= '0;
            row_q   <= '0;
            for (int i = 0; i < NB; i++) begin
                buf_q[i] <= '0;
            end
            dout_q  <= '0;
            valid_q <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            end_q   <= end_d;
        end
    end

    assign data_out = dout_q;
    assign valid_op = valid_q;
    assign end_op   = end_q;
endmodule
`default_nettype wire

// File: tb/tb_pool_engine.sv
`default_nettype none
// Self-checking bench for pool_engine (M=4, P=2, DW=32) against a window-level pooling model.
module tb_pool_engine;
    localparam int DW = 32;
    localparam int M  = 4;
    localparam int P  = 2;
`ifdef POOL_ENGINE_AVG_EN
    localparam bit AVG_BUILD = 1'b1;
`else
    localparam bit AVG_BUILD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          master_rst = 1'b1;
    logic          ce = 1'b0;
    logic          mode = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          valid_op, end_op;

    int errors = 0;
    int checks = 0;
    int stray_end = 0;
    logic [DW-1:0] got_q[$];
    bit            got_end_q[$];
    logic [DW-1:0] exp_q[$];
    bit            exp_end_q[$];

    pool_engine #(.DW(DW), .M(M), .P(P)) dut (
        .clk(clk), .master_rst(master_rst), .ce(ce), .mode(mode),
        .data_in(data_in), .data_out(data_out), .valid_op(valid_op), .end_op(end_op)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, then record any output pulse seen 1 ns after the edge.
    task automatic step(input bit c, input int d, input bit m);
        ce = c; data_in = d; mode = m;
        @(posedge clk); #1;
        if (valid_op) begin
            got_q.push_back(data_out);
            got_end_q.push_back(end_op);
        end else if (end_op) begin
            stray_end++;
        end
    endtask

    task automatic apply_reset();
        master_rst = 1'b1; ce = 1'b0;
        @(posedge clk); #1;
        master_rst = 1'b0;
    endtask

    task automatic clear_sb();
        got_q.delete(); got_end_q.delete(); exp_q.delete(); exp_end_q.delete();
        stray_end = 0;
    endtask

    task automatic send_map(input int px[M*M], input bit m);
        for (int i = 0; i < M*M; i++) step(1'b1, px[i], m);
    endtask

    // Reference: pool each PxP window of a complete map directly.
    function automatic void model_map(input int px[M*M], input bit avg);
        longint mx, s, v, q;
        for (int wr = 0; wr < M/P; wr++) begin
            for (int wc = 0; wc < M/P; wc++) begin
                mx = px[wr*P*M + wc*P];
                s  = 0;
                for (int i = 0; i < P; i++) begin
                    for (int j = 0; j < P; j++) begin
                        v = px[(wr*P + i)*M + wc*P + j];
                        s += v;
                        if (v > mx) mx = v;
                    end
                end
                if (avg) begin
                    q = s / (P*P);
                    if ((s % (P*P)) != 0 && s < 0) q = q - 1;
                    exp_q.push_back(q[DW-1:0]);
                end else begin
                    exp_q.push_back(mx[DW-1:0]);
                end
                exp_end_q.push_back(wr == M/P-1 && wc == M/P-1);
            end
        end
    endfunction

    task automatic test_reset();
        master_rst = 1'b1; ce = 1'b1; data_in = $urandom;
        @(posedge clk); #1;
        checks++;
        if (data_out !== '0 || valid_op !== 1'b0 || end_op !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got data_out=%0d valid=%b end=%b, want 0 0 0", data_out, valid_op, end_op);
        end
        master_rst = 1'b0; ce = 1'b0;
    endtask

    task automatic test_ramp(input bit m);
        int px[M*M];
        apply_reset(); clear_sb();
        for (int i = 0; i < M*M; i++) px[i] = i;
        model_map(px, m && AVG_BUILD);
        send_map(px, m);
        step(1'b0, 0, 1'b0);
        checks++;
        if (got_q.size() != exp_q.size() || stray_end != 0) begin
            errors++;
            $display("FAIL ramp_m%0b count: got %0d outputs, %0d stray end_op, want %0d", m, got_q.size(), stray_end, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_end_q[i] !== exp_end_q[i]) begin
                errors++;
                $display("FAIL ramp_m%0b out%0d: got %0d end=%b, want %0d end=%b", m, i, $signed(got_q[i]), got_end_q[i], $signed(exp_q[i]), exp_end_q[i]);
            end
        end
    endtask

    task automatic test_negative_window();
        int px[M*M];
        logic [DW-1:0] want0, got0;
        for (int m = 0; m < 2; m++) begin
            apply_reset(); clear_sb();
            for (int i = 0; i < M*M; i++) px[i] = 0;
            px[0] = -1; px[1] = -2; px[4] = -3; px[5] = -4;
            send_map(px, m[0]);
            want0 = (m[0] && AVG_BUILD) ? -3 : -1;
            got0  = (got_q.size() > 0) ? got_q[0] : 'x;
            checks++;
            if (got0 !== want0) begin
                errors++;
                $display("FAIL neg_window_m%0d: got %0d, want %0d", m, $signed(got0), $signed(want0));
            end
        end
    endtask

    task automatic test_stall();
        int px[M*M];
        apply_reset(); clear_sb();
        for (int i = 0; i < M*M; i++) px[i] = i;
        model_map(px, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, px[i], 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, $urandom, 1'b1);
            checks++;
            if (valid_op !== 1'b0 || end_op !== 1'b0 || data_out !== 32'd5) begin
                errors++;
                $display("FAIL stall_hold%0d: got data_out=%0d valid=%b end=%b, want 5 0 0", k, data_out, valid_op, end_op);
            end
        end
        for (int i = 7; i < M*M; i++) step(1'b1, px[i], 1'b0);
        checks++;
        if (got_q.size() != exp_q.size() || stray_end != 0) begin
            errors++;
            $display("FAIL stall count: got %0d outputs, %0d stray end_op, want %0d", got_q.size(), stray_end, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_end_q[i] !== exp_end_q[i]) begin
                errors++;
                $display("FAIL stall out%0d: got %0d end=%b, want %0d end=%b", i, $signed(got_q[i]), got_end_q[i], $signed(exp_q[i]), exp_end_q[i]);
            end
        end
    endtask

    task automatic test_reset_midmap();
        int px[M*M];
        apply_reset();
        for (int i = 0; i < M*M; i++) px[i] = i;
        for (int i = 0; i < 10; i++) step(1'b1, px[i], 1'b0);
        clear_sb();
        master_rst = 1'b1; ce = 1'b1; data_in = 99;
        @(posedge clk); #1;
        checks++;
        if (data_out !== '0 || valid_op !== 1'b0 || end_op !== 1'b0) begin
            errors++;
            $display("FAIL midmap_reset: got data_out=%0d valid=%b end=%b, want 0 0 0", data_out, valid_op, end_op);
        end
        master_rst = 1'b0;
        model_map(px, 1'b0);
        send_map(px, 1'b0);
        checks++;
        if (got_q.size() != exp_q.size() || stray_end != 0) begin
            errors++;
            $display("FAIL midmap count: got %0d outputs, %0d stray end_op, want %0d", got_q.size(), stray_end, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_end_q[i] !== exp_end_q[i]) begin
                errors++;
                $display("FAIL midmap out%0d: got %0d end=%b, want %0d end=%b", i, $signed(got_q[i]), got_end_q[i], $signed(exp_q[i]), exp_end_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int px1[M*M], px2[M*M];
        int ends;
        apply_reset(); clear_sb();
        for (int i = 0; i < M*M; i++) begin px1[i] = i; px2[i] = 16 + i; end
        model_map(px1, 1'b0);
        model_map(px2, 1'b0);
        send_map(px1, 1'b0);
        for (int i = 0; i < M*M; i++) step(1'b1, px2[i], (i >= 4));
        ends = 0;
        foreach (got_end_q[i]) if (got_end_q[i]) ends++;
        checks++;
        if (ends != 2 || stray_end != 0) begin
            errors++;
            $display("FAIL b2b end_count: got %0d (+%0d stray), want 2", ends, stray_end);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b count: got %0d outputs, want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_end_q[i] !== exp_end_q[i]) begin
                errors++;
                $display("FAIL b2b out%0d: got %0d end=%b, want %0d end=%b", i, $signed(got_q[i]), got_end_q[i], $signed(exp_q[i]), exp_end_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int px[M*M];
        bit m0;
        apply_reset(); clear_sb();
        for (int map = 0; map < 8; map++) begin
            m0 = 1'($urandom);
            for (int i = 0; i < M*M; i++) px[i] = (map < 4) ? $urandom : $urandom_range(0, 40) - 20;
            model_map(px, m0 && AVG_BUILD);
            for (int i = 0; i < M*M; i++) begin
                for (int k = $urandom_range(0, 2); k > 0; k--) step(1'b0, $urandom, 1'($urandom));
                step(1'b1, px[i], (i == 0) ? m0 : 1'($urandom));
            end
        end
        checks++;
        if (got_q.size() != exp_q.size() || stray_end != 0) begin
            errors++;
            $display("FAIL random count: got %0d outputs, %0d stray end_op, want %0d", got_q.size(), stray_end, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i] || got_end_q[i] !== exp_end_q[i]) begin
                errors++;
                $display("FAIL random out%0d: got %0d end=%b, want %0d end=%b", i, $signed(got_q[i]), got_end_q[i], $signed(exp_q[i]), exp_end_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp(1'b0);
        test_ramp(1'b1);
        test_negative_window();
        test_stall();
        test_reset_midmap();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pool_engine.md
POOL_ENGINE -- requirements
Module: pool_engine

Interface
REQ-001 Parameter DW, default 32, signed pixel width in bits.
REQ-002 Parameter M, default 4, square input feature-map side in pixels; M multiple of P.
REQ-003 Parameter P, default 2, pool window side and stride (non-overlapping); legal values 2, 4, 8.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 master_rst  input  1  reset, synchronous, active-high.
REQ-006 ce  input  1  pixel-valid / clock-enable; data_in consumed only when ce=1.
REQ-007 mode  input  1  0=max pool, 1=average pool.
REQ-008 data_in  input  DW  signed pixel, row-major raster order.
REQ-009 data_out  output  DW  signed pooled result, registered.
REQ-010 valid_op  output  1  one-cycle pulse marking data_out valid.
REQ-011 end_op  output  1  one-cycle pulse coincident with the final pooled result of a map.

Function
REQ-012 Column counter col and row counter row, 0..M-1, advance only on ce=1 cycles; col wraps M-1->0 and increments row; row wraps M-1->0 after the final pixel, so the next map follows with no gap.
REQ-013 Partial-result buffer holds M/P entries, one per pooled column, indexed col/P; entry width DW in max mode and DW+2*log2(P) in average mode.
REQ-014 First pixel of a window (row%P==0 and col%P==0) loads the entry with data_in (sign-extended); every other window pixel updates it: max mode keeps the signed maximum, average mode adds.
REQ-015 Window completes on the pixel where row%P==P-1 and col%P==P-1; on the following edge data_out takes the result and valid_op=1 for exactly one cycle (latency 1 cycle from the completing pixel).
REQ-016 Max result = signed maximum of the P*P pixels; ties irrelevant.
REQ-017 Average result = window sum arithmetically shifted right by 2*log2(P) (floor toward -infinity), truncated to DW bits; no rounding, no saturation.
REQ-018 end_op=1 in the same cycle as the valid_op of the window completing at row=M-1, col=M-1; 0 otherwise.
REQ-019 mode latched on the first pixel of each map (row=0, col=0, ce=1); changes mid-map have no effect until the next map.
REQ-020 ce=0 freezes counters, buffer and latched mode; valid_op/end_op are 0 in any cycle not following a completing pixel; data_out holds its last value between pulses.
REQ-021 Output count per map is exactly (M/P)^2, in raster order of pooled positions.

Reset
REQ-022 master_rst=1 on a rising edge clears col, row, partial buffer and latched mode to 0, and drives data_out=0, valid_op=0, end_op=0 on the next cycle.
REQ-023 master_rst has priority over ce; reset mid-map discards the partial map, and the first ce=1 pixel after reset is treated as row 0, col 0.

Configuration
REQ-024 Macro POOL_ENGINE_AVG_EN: defined -> average datapath, widened buffer and mode input behave per REQ-014/017/019.
REQ-025 Macro undefined -> mode port exists but is ignored; max pooling only; buffer width DW; no adder or shifter synthesised.

Verification (M=4, P=2, DW=32, POOL_ENGINE_AVG_EN defined)
REQ-026 Reset, then ce=1 with data_in 0..15 consecutive, mode=0 -> valid_op pulses with data_out 5, 7, 13, 15; end_op with 15 only.
REQ-027 Same stream, mode=1 -> data_out 2, 4, 10, 12; end_op with 12.
REQ-028 Window of -1,-2,-3,-4 (pixels at positions 0,1,4,5) -> max -1; average -3 (floor of -2.5).
REQ-029 Stream 0..15 with ce=0 for 3 cycles after pixel 6 -> outputs and order identical to REQ-026, each pulse delayed by the stall; no spurious pulses during the stall.
REQ-030 master_rst asserted after pixel 9, then 0..15 restarted -> no output from the aborted map; outputs 5, 7, 13, 15 as REQ-026; data_out=0 in the cycle after reset.
REQ-031 Two maps back-to-back (0..15 then 16..31, mode toggled to 1 at pixel 20) -> second map outputs 21, 23, 29, 31 (mode ignored until next map); two end_op pulses total.
